// File: rtl/wir_ctrl.sv
// IEEE 1500 WIR controller: serial instruction load/update, one-hot decode, bypass reg, WSO mux, DR shift counter.
// Latency: WIR shift/update 1 clk each; chain_done 1 clk after the terminal data shift; wso is combinational.
// Backpressure: none; every capture/shift/update strobe is acted on in the cycle it is presented.
module wir_ctrl #(
  parameter int WIR_W     = 3,
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select_wir,
  input  logic             capture_wr,
  input  logic             shift_wr,
  input  logic             update_wr,
  input  logic             wsi,
  input  logic             wbr_so,
  input  logic             core_so,
  output logic             wso,
  output logic             wir_bypass,
  output logic             wir_wpc,
  output logic             wir_extest,
  output logic             wir_intest,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             chain_done
);

  typedef enum logic [1:0] {
    INS_BYPASS = 2'd0,
    INS_EXTEST = 2'd1,
    INS_INTEST = 2'd2,
    INS_WPC    = 2'd3
  } ins_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WIR_W-1:0] WIR_CAP  = WIR_W'(1);

  logic [WIR_W-1:0] wir_shift;
  logic [WIR_W-1:0] wir_upd;
  logic             bypass_reg;
  ins_e             ins;

  logic wir_cap, wir_sh, wir_up;
  logic dr_cap, dr_sh;

  // Opcodes with any upper bit set are illegal and fall back to BYPASS.
  always_comb begin
    ins = INS_BYPASS;
    if (wir_upd[WIR_W-1:2] == '0) begin
      ins = ins_e'(wir_upd[1:0]);
    end
  end

  assign wir_bypass = (ins == INS_BYPASS);
  assign wir_extest = (ins == INS_EXTEST);
  assign wir_intest = (ins == INS_INTEST);
  assign wir_wpc    = (ins == INS_WPC);

  assign wir_cap = select_wir & capture_wr;
  assign wir_sh  = select_wir & shift_wr & ~capture_wr;
  assign wir_up  = select_wir & update_wr & ~capture_wr & ~shift_wr;
  assign dr_cap  = ~select_wir & capture_wr;
  assign dr_sh   = ~select_wir & shift_wr & ~capture_wr;

  always_comb begin
    wso = bypass_reg;
    if (select_wir) begin
      wso = wir_shift[0];
    end else begin
      case (ins)
        INS_EXTEST, INS_INTEST: wso = wbr_so;
        INS_WPC:                wso = core_so;
        default:                wso = bypass_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wir_shift  <= '0;
      wir_upd    <= '0;
      bypass_reg <= 1'b0;
      shift_cnt  <= '0;
      chain_done <= 1'b0;
    end else begin
      chain_done <= 1'b0;
      if (wir_cap) begin
        wir_shift <= WIR_CAP;
      end else if (wir_sh) begin
        wir_shift <= {wsi, wir_shift[WIR_W-1:1]};
      end else if (wir_up) begin
        wir_upd <= wir_shift;
      end

      if (dr_cap) begin
        shift_cnt <= '0;
        if (ins == INS_BYPASS) bypass_reg <= 1'b0;
      end else if (dr_sh) begin
        // The counter saturates, so the terminal count is crossed only once per capture.
        if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
        if (shift_cnt == CNT_TERM) chain_done <= 1'b1;
        if (ins == INS_BYPASS) bypass_reg <= wsi;
      end
    end
  end

endmodule

// File: tb/tb_wir_ctrl.sv
// Directed + randomized bench for wir_ctrl against an opcode-level reference model.
module tb_wir_ctrl;

  localparam int CHAIN_LEN = 8;
  localparam int CNT_MAX   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       select_wir = 1'b0;
  logic       capture_wr = 1'b0;
  logic       shift_wr = 1'b0;
  logic       update_wr = 1'b0;
  logic       wsi = 1'b0;
  logic       wbr_so = 1'b0;
  logic       core_so = 1'b0;
  logic       wso;
  logic       wir_bypass, wir_wpc, wir_extest, wir_intest;
  logic [7:0] shift_cnt;
  logic       chain_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: opcodes and counts as plain integers.
  int m_shift, m_upd, m_byp, m_cnt, m_done;

  wir_ctrl #(.WIR_W(3), .CHAIN_LEN(CHAIN_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .select_wir(select_wir), .capture_wr(capture_wr),
    .shift_wr(shift_wr), .update_wr(update_wr), .wsi(wsi), .wbr_so(wbr_so),
    .core_so(core_so), .wso(wso), .wir_bypass(wir_bypass), .wir_wpc(wir_wpc),
    .wir_extest(wir_extest), .wir_intest(wir_intest), .shift_cnt(shift_cnt),
    .chain_done(chain_done)
  );

  always #5 clk = ~clk;

  function automatic int active_op();
    return (m_upd < 4) ? m_upd : 0;
  endfunction

  function automatic int exp_wso();
    if (select_wir) return m_shift % 2;
    case (active_op())
      0:       return m_byp;
      3:       return int'(core_so);
      default: return int'(wbr_so);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("bypass", {31'd0, wir_bypass}, (active_op() == 0) ? 1 : 0);
    chk("extest", {31'd0, wir_extest}, (active_op() == 1) ? 1 : 0);
    chk("intest", {31'd0, wir_intest}, (active_op() == 2) ? 1 : 0);
    chk("wpc",    {31'd0, wir_wpc},    (active_op() == 3) ? 1 : 0);
    chk("shift_cnt", {24'd0, shift_cnt}, m_cnt);
    chk("chain_done", {31'd0, chain_done}, m_done);
  endtask

  task automatic model_reset();
    m_shift = 0; m_upd = 0; m_byp = 0; m_cnt = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic sel, input logic cap, input logic sh,
                            input logic upd, input logic w);
    int op;
    op = active_op();
    m_done = 0;
    if (sel) begin
      if (cap)      m_shift = 1;
      else if (sh)  m_shift = (m_shift / 2) + (w ? 4 : 0);
      else if (upd) m_upd = m_shift;
    end else begin
      if (cap) begin
        m_cnt = 0;
        if (op == 0) m_byp = 0;
      end else if (sh) begin
        if (m_cnt == CHAIN_LEN - 1) m_done = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (op == 0) m_byp = int'(w);
      end
    end
  endtask

  // Called 1 time unit after a rising edge; wso is checked before the next edge.
  task automatic cyc(input logic sel, input logic cap, input logic sh,
                     input logic upd, input logic w);
    select_wir = sel; capture_wr = cap; shift_wr = sh; update_wr = upd; wsi = w;
    wbr_so = 1'($urandom); core_so = 1'($urandom);
    #1 chk("wso", {31'd0, wso}, exp_wso());
    @(posedge clk);
    model_edge(sel, cap, sh, upd, w);
    #1 chk_state();
  endtask

  task automatic load_op(input int op);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1'((op >> i) & 1));
    cyc(1, 0, 0, 1, 0);
  endtask

  initial begin
    logic sel_r;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_state();
    chk("reset_wso", {31'd0, wso}, 0);
    rst = 1'b0;

    // INTEST load and decode.
    load_op(2);
    chk("intest_loaded", {31'd0, wir_intest}, 1);

    // Capture 001 then shift out, then illegal opcode 111.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
    load_op(7);
    chk("illegal_bypass", {31'd0, wir_bypass}, 1);

    // WPC chain: 8 shifts pulse chain_done, then saturate without a second pulse.
    load_op(3);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < CHAIN_LEN; i++) cyc(0, 0, 1, 0, 1'($urandom));
    chk("chain_done_pulse", {31'd0, chain_done}, 1);
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, 0, 1'($urandom));
    chk("cnt_saturated", {24'd0, shift_cnt}, CNT_MAX);

    // BYPASS data path, then capture beating shift.
    load_op(0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("capture_wins", {31'd0, wso}, 0);

    // Asynchronous reset in the middle of a WIR shift with EXTEST active.
    load_op(1);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1'($urandom));
    select_wir = 1'b1; capture_wr = 1'b0; shift_wr = 1'b1; update_wr = 1'b0; wsi = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_state();
    @(posedge clk);
    #1 chk_state();
    rst = 1'b0;
    cyc(1, 0, 0, 1, 0);
    chk("post_reset_update", {31'd0, wir_bypass}, 1);

    // Randomized traffic.
    sel_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) sel_r = ~sel_r;
      cyc(sel_r, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
